// File: rtl/mux_scan_nto1.sv
// rtl/mux_scan_nto1.sv - N-to-1 registered mux with round-robin auto-scan sequencer
// Define MUX_SCAN_MASK_EN to add the ch_mask port that lets auto-scan skip disabled channels.
module mux_scan_nto1 #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DWELL    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic                      en,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel_in,
`ifdef MUX_SCAN_MASK_EN
  input  logic [CHANNELS-1:0]       ch_mask,
`endif
  output logic [WIDTH-1:0]          dout,
  output logic                      dout_valid,
  output logic [SEL_W-1:0]          cur_sel,
  output logic                      wrap,
  output logic                      sel_err
);

  localparam int                CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W:0]    CH_LIMIT = (SEL_W + 1)'(CHANNELS);
  localparam logic [SEL_W-1:0]  SEL_LAST = SEL_W'(CHANNELS - 1);

  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  logic [SEL_W-1:0] next_sel;
  logic [WIDTH-1:0] man_data, cur_data, nxt_data;
  logic             sel_in_ok;

  assign sel_in_ok = ({1'b0, sel_in} < CH_LIMIT);

`ifdef MUX_SCAN_MASK_EN
  logic [SEL_W-1:0] hi_sel, lo_sel;
  logic             hi_ok, lo_ok;

  // Descending walk so the lowest enabled channel above (or below) cur_sel wins.
  always_comb begin
    hi_sel = '0;
    lo_sel = '0;
    hi_ok  = 1'b0;
    lo_ok  = 1'b0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (ch_mask[k] && (SEL_W'(k) > sel_q)) begin
        hi_sel = SEL_W'(k);
        hi_ok  = 1'b1;
      end
      if (ch_mask[k] && (SEL_W'(k) < sel_q)) begin
        lo_sel = SEL_W'(k);
        lo_ok  = 1'b1;
      end
    end
    if (hi_ok) begin
      next_sel = hi_sel;
    end else if (lo_ok) begin
      next_sel = lo_sel;
    end else begin
      next_sel = sel_q;
    end
  end
`else
  assign next_sel = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
`endif

  // Out-of-range manual selects match no channel and so yield zero data.
  always_comb begin
    man_data = '0;
    cur_data = '0;
    nxt_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel_in == SEL_W'(k)) man_data = din[k*WIDTH +: WIDTH];
      if (sel_q == SEL_W'(k))  cur_data = din[k*WIDTH +: WIDTH];
      if (next_sel == SEL_W'(k)) nxt_data = din[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    dout_d  = dout_q;
    valid_d = valid_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (en) begin
      valid_d = 1'b1;
      if (!mode) begin
        // Manual mode parks the dwell counter so a switch to auto starts a fresh dwell.
        cnt_d = '0;
        if (sel_in_ok) begin
          sel_d  = sel_in;
          dout_d = man_data;
        end else begin
          dout_d = '0;
          err_d  = 1'b1;
        end
      end else if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        sel_d  = next_sel;
        dout_d = nxt_data;
        wrap_d = (next_sel < sel_q);
      end else begin
        cnt_d  = cnt_q + CNT_W'(1);
        dout_d = cur_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
      sel_q   <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign cur_sel    = sel_q;
  assign wrap       = wrap_q;
  assign sel_err    = err_q;

endmodule
